// File: rtl/huffman_dc_dec_if.sv
// Bit-stream input and DC-result output bundle of the JPEG DC Huffman decoder.
// The decoder takes the slave view; the bit source and result consumer take the master view.
interface huffman_dc_dec_if #(
  parameter int DC_W = 12
);
  logic                   bit_in;
  logic                   bit_valid;
  logic                   bit_ready;
  logic                   is_luminance;
  logic signed [DC_W-1:0] dc_out;
  logic [3:0]             dc_size;
  logic                   dc_valid;
  logic                   dc_ready;
  logic                   err;

  modport master (
    output bit_in, bit_valid, is_luminance, dc_ready,
    input  bit_ready, dc_out, dc_size, dc_valid, err
  );

  modport slave (
    input  bit_in, bit_valid, is_luminance, dc_ready,
    output bit_ready, dc_out, dc_size, dc_valid, err
  );
endinterface

// File: rtl/huffman_dc_dec.sv
// Bit-serial JPEG DC Huffman decoder: matches one Annex K DC category codeword,
// shifts in the amplitude bits and emits the sign-extended DC difference.
module huffman_dc_dec #(
  parameter int DC_W    = 12,
  parameter int MAX_CAT = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  huffman_dc_dec_if.slave  dec_if
);

  typedef enum logic [1:0] {
    S_CODE = 2'd0,
    S_AMP  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  localparam logic [DC_W-1:0] ONE       = {{(DC_W-1){1'b0}}, 1'b1};
  localparam logic [4:0]      MAX_CAT_L = 5'(MAX_CAT);

  // Returns {hit, category}; code holds exactly len bits, right-aligned.
  function automatic logic [4:0] dc_lookup(input logic luma, input logic [3:0] len,
                                           input logic [10:0] code);
    logic [10:0] tail;
    tail = (11'd1 << len) - 11'd2;
    dc_lookup = 5'd0;
    if (luma) begin
      if (len == 4'd2 && code[1:0] == 2'b00)
        dc_lookup = 5'b1_0000;
      else if (len == 4'd3 && code[2:0] >= 3'b010 && code[2:0] <= 3'b110)
        dc_lookup = {1'b1, 1'b0, code[2:0] - 3'd1};
      else if (len >= 4'd4 && len <= 4'd9 && code == tail)
        dc_lookup = {1'b1, len + 4'd2};
      else
        dc_lookup = 5'd0;
    end else begin
      if (len == 4'd2 && code[1:0] != 2'b11)
        dc_lookup = {1'b1, 2'b00, code[1:0]};
      else if (len >= 4'd3 && len <= 4'd11 && code == tail)
        dc_lookup = {1'b1, len};
      else
        dc_lookup = 5'd0;
    end
  endfunction

  state_e          state_q, state_d;
  logic [10:0]     code_q, code_d;
  logic [3:0]      len_q, len_d;
  logic            luma_q, luma_d;
  logic [DC_W-1:0] amp_q, amp_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      cat_q, cat_d;
  logic [DC_W-1:0] dc_out_q, dc_out_d;
  logic [3:0]      dc_size_q, dc_size_d;
  logic            dc_valid_q, dc_valid_d;
  logic            err_q, err_d;

  logic            accept_s;
  logic [10:0]     code_n_s;
  logic [3:0]      len_n_s;
  logic            luma_n_s;
  logic [4:0]      look_s;
  logic [3:0]      max_len_s;
  logic [DC_W-1:0] amp_n_s;
  logic [DC_W-1:0] ones_s;
  logic            sign_s;

  assign dec_if.bit_ready = (state_q != S_OUT);
  assign dec_if.dc_out    = dc_out_q;
  assign dec_if.dc_size   = dc_size_q;
  assign dec_if.dc_valid  = dc_valid_q;
  assign dec_if.err       = err_q;

  // Next-state, datapath and output computation.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    len_d      = len_q;
    luma_d     = luma_q;
    amp_d      = amp_q;
    cnt_d      = cnt_q;
    cat_d      = cat_q;
    dc_out_d   = dc_out_q;
    dc_size_d  = dc_size_q;
    err_d      = 1'b0;

    accept_s  = dec_if.bit_valid && (state_q != S_OUT);
    code_n_s  = (code_q << 1) | {10'd0, dec_if.bit_in};
    len_n_s   = len_q + 4'd1;
    luma_n_s  = (len_q == 4'd0) ? dec_if.is_luminance : luma_q;
    look_s    = dc_lookup(luma_n_s, len_n_s, code_n_s);
    max_len_s = luma_n_s ? 4'd9 : 4'd11;
    amp_n_s   = (amp_q << 1) | {{(DC_W-1){1'b0}}, dec_if.bit_in};
    ones_s    = (ONE << cat_q) - ONE;
    // A set leading amplitude bit means a positive difference.
    sign_s    = |(amp_n_s & (ONE << (cat_q - 4'd1)));

    case (state_q)
      S_CODE: begin
        if (accept_s) begin
          code_d = code_n_s;
          len_d  = len_n_s;
          luma_d = luma_n_s;
          if ((look_s[4] && ({1'b0, look_s[3:0]} > MAX_CAT_L)) ||
              (!look_s[4] && (len_n_s == max_len_s))) begin
            err_d  = 1'b1;
            code_d = 11'd0;
            len_d  = 4'd0;
          end else if (look_s[4]) begin
            code_d = 11'd0;
            len_d  = 4'd0;
            if (look_s[3:0] == 4'd0) begin
              state_d   = S_OUT;
              dc_out_d  = {DC_W{1'b0}};
              dc_size_d = 4'd0;
            end else begin
              state_d = S_AMP;
              cnt_d   = look_s[3:0];
              cat_d   = look_s[3:0];
              amp_d   = {DC_W{1'b0}};
            end
          end else begin
            state_d = S_CODE;
          end
        end else begin
          state_d = S_CODE;
        end
      end
      S_AMP: begin
        if (accept_s) begin
          amp_d = amp_n_s;
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d   = S_OUT;
            dc_size_d = cat_q;
            dc_out_d  = sign_s ? amp_n_s : (amp_n_s - ones_s);
          end else begin
            state_d = S_AMP;
          end
        end else begin
          state_d = S_AMP;
        end
      end
      S_OUT: begin
        if (dec_if.dc_ready) begin
          state_d = S_CODE;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d = S_CODE;
      end
    endcase

    dc_valid_d = (state_d == S_OUT);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_CODE;
      code_q     <= 11'd0;
      len_q      <= 4'd0;
      luma_q     <= 1'b0;
      amp_q      <= {DC_W{1'b0}};
      cnt_q      <= 4'd0;
      cat_q      <= 4'd0;
      dc_out_q   <= {DC_W{1'b0}};
      dc_size_q  <= 4'd0;
      dc_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      len_q      <= len_d;
      luma_q     <= luma_d;
      amp_q      <= amp_d;
      cnt_q      <= cnt_d;
      cat_q      <= cat_d;
      dc_out_q   <= dc_out_d;
      dc_size_q  <= dc_size_d;
      dc_valid_q <= dc_valid_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_huffman_dc_dec.sv
// Self-checking bench for huffman_dc_dec: directed JPEG DC vectors, random symbols
// encoded by a table-driven reference encoder, backpressure, illegal codes and reset.
module tb_huffman_dc_dec;
  localparam int DC_W = 12;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  huffman_dc_dec_if #(.DC_W(DC_W)) bif ();
  huffman_dc_dec_if #(.DC_W(DC_W)) bif9 ();

  huffman_dc_dec #(.DC_W(DC_W), .MAX_CAT(11)) dut  (.clk(clk), .rst_n(rst_n), .dec_if(bif));
  huffman_dc_dec #(.DC_W(DC_W), .MAX_CAT(9))  dut9 (.clk(clk), .rst_n(rst_n), .dec_if(bif9));

  assign bif9.bit_in       = bif.bit_in;
  assign bif9.bit_valid    = bif.bit_valid;
  assign bif9.is_luminance = bif.is_luminance;
  assign bif9.dc_ready     = 1'b1;

  int checks    = 0;
  int failures  = 0;
  int err_cnt   = 0;
  int valid_cnt = 0;

  // Annex K DC code tables, indexed by category.
  int luma_len   [12] = '{2, 3, 3, 3, 3, 3, 4, 5, 6, 7, 8, 9};
  int luma_code  [12] = '{0, 2, 3, 4, 5, 6, 14, 30, 62, 126, 254, 510};
  int chroma_len [12] = '{2, 2, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
  int chroma_code[12] = '{0, 1, 2, 6, 14, 30, 62, 126, 254, 510, 1022, 2046};

  // Directed vectors: table select, stream bits (right-aligned, MSB first), length, expectations.
  bit        d_luma[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  int        d_bits[6] = '{32'b100101, 32'b100010, 32'b010, 32'b00, 32'hFF400, 32'hFF000};
  int        d_n   [6] = '{6, 6, 3, 2, 20, 20};
  int        d_size[6] = '{3, 3, 1, 0, 11, 11};
  int        d_val [6] = '{5, -5, -1, 0, 1024, -2047};

  // Counts err pulses and dc_valid cycles away from the active edge.
  always @(negedge clk) begin
    if (bif.err === 1'b1) err_cnt <= err_cnt + 1;
    if (bif.dc_valid === 1'b1) valid_cnt <= valid_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Reference encoder: category, amplitude and codeword straight from the JPEG rules.
  function automatic void encode(input bit luma, input int v, output logic [31:0] bits,
                                 output int n, output int c);
    int mag;
    int amp;
    int len;
    int code;
    mag = (v < 0) ? -v : v;
    c = 0;
    while ((1 << c) <= mag) c++;
    amp  = (v >= 0) ? v : v + (1 << c) - 1;
    len  = luma ? luma_len[c] : chroma_len[c];
    code = luma ? luma_code[c] : chroma_code[c];
    bits = (32'(code) << c) | 32'(amp);
    n    = len + c;
  endfunction

  task automatic send_bit(input logic b, input bit gaps, output bit ok);
    ok = 1'b0;
    if (gaps) begin
      bif.bit_valid = 1'b0;
      bif.bit_in    = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) step();
    end
    bif.bit_in    = b;
    bif.bit_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bif.bit_ready === 1'b1) begin
        ok = 1'b1;
        step();
        break;
      end
      step();
    end
    bif.bit_valid = 1'b0;
  endtask

  task automatic send_bits(input string name, input bit luma, input logic [31:0] bits,
                           input int n, input bit gaps, input bit scramble);
    bit ok;
    bif.is_luminance = luma;
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(bits[i], gaps, ok);
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL %s timeout: bit_ready=%0b required 1", name, bif.bit_ready);
        break;
      end
      if (scramble && i == n - 1) bif.is_luminance = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic decode_symbol(input string name, input bit luma, input logic [31:0] bits,
                               input int n, input int exp_size, input int exp_val,
                               input bit gaps, input bit scramble);
    int v0;
    int e0;
    logic signed [DC_W-1:0] ev;
    logic [3:0] es;
    ev = exp_val[DC_W-1:0];
    es = exp_size[3:0];
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bits(name, luma, bits, n, gaps, scramble);
    checks++;
    if (bif.dc_valid !== 1'b1 || bif.dc_size !== es || bif.dc_out !== ev) begin
      failures++;
      $display("FAIL %s: dc_valid=%0b dc_size=%0d dc_out=%0d, required 1 %0d %0d",
               name, bif.dc_valid, bif.dc_size, bif.dc_out, es, ev);
    end
    step();
    checks++;
    if (valid_cnt - v0 != 1 || err_cnt != e0) begin
      failures++;
      $display("FAIL %s valid/err count: valid_cycles=%0d err=%0d, required 1 0",
               name, valid_cnt - v0, err_cnt - e0);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bif.dc_valid !== 1'b0 || bif.dc_out !== 12'sd0 || bif.dc_size !== 4'd0 ||
        bif.err !== 1'b0 || bif.bit_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset: valid=%0b out=%0d size=%0d err=%0b ready=%0b, required 0 0 0 0 1",
               bif.dc_valid, bif.dc_out, bif.dc_size, bif.err, bif.bit_ready);
    end
  endtask

  task automatic test_directed(input bit gaps);
    for (int k = 0; k < 6; k++) begin
      decode_symbol(gaps ? "stall_vec" : "vec", d_luma[k], d_bits[k], d_n[k],
                    d_size[k], d_val[k], gaps, gaps);
    end
  endtask

  task automatic test_random();
    logic [31:0] bits;
    int n;
    int c;
    int cat;
    int v;
    bit luma;
    for (int k = 0; k < 40; k++) begin
      luma = 1'($urandom_range(0, 1));
      cat  = $urandom_range(0, 11);
      if (cat == 0) v = 0;
      else v = $urandom_range((1 << cat) - 1, 1 << (cat - 1));
      if (cat != 0 && $urandom_range(0, 1) == 1) v = -v;
      encode(luma, v, bits, n, c);
      decode_symbol("random", luma, bits, n, c, v, 1'b1, 1'b1);
    end
  endtask

  task automatic test_backpressure();
    bif.dc_ready = 1'b0;
    send_bits("bp", 1'b1, 32'b100101, 6, 1'b0, 1'b0);
    bif.bit_in    = 1'b1;
    bif.bit_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (bif.bit_ready !== 1'b0 || bif.dc_valid !== 1'b1 || bif.dc_out !== 12'sd5 ||
          bif.dc_size !== 4'd3) begin
        failures++;
        $display("FAIL bp_hold: ready=%0b valid=%0b out=%0d size=%0d, required 0 1 5 3",
                 bif.bit_ready, bif.dc_valid, bif.dc_out, bif.dc_size);
      end
      step();
    end
    bif.dc_ready = 1'b1;
    step();
    bif.bit_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bif.bit_ready !== 1'b1 || bif.dc_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: ready=%0b valid=%0b, required 1 0", bif.bit_ready, bif.dc_valid);
    end
    step();
    decode_symbol("bp_next", 1'b1, 32'b00, 2, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_illegal(input string name, input bit luma, input logic [31:0] bits,
                              input int n);
    int e0;
    e0 = err_cnt;
    send_bits(name, luma, bits, n, 1'b0, 1'b0);
    checks++;
    if (bif.err !== 1'b1 || bif.dc_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s: err=%0b valid=%0b, required 1 0", name, bif.err, bif.dc_valid);
    end
    step();
    checks++;
    if (bif.err !== 1'b0 || err_cnt - e0 != 1) begin
      failures++;
      $display("FAIL %s pulse: err=%0b pulses=%0d, required 0 1", name, bif.err, err_cnt - e0);
    end
    decode_symbol({name, "_next"}, 1'b1, 32'b00, 2, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_maxcat();
    do_reset();
    send_bits("maxcat", 1'b1, 32'hFE, 8, 1'b0, 1'b0);
    checks++;
    if (bif9.err !== 1'b1 || bif.err !== 1'b0) begin
      failures++;
      $display("FAIL maxcat: err(MAX_CAT=9)=%0b err(MAX_CAT=11)=%0b, required 1 0",
               bif9.err, bif.err);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    int v0;
    int e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bits("rst_amp", 1'b1, 32'b10010, 5, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    test_reset();
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (valid_cnt != v0 || err_cnt != e0) begin
      failures++;
      $display("FAIL rst_amp counts: valid_cycles=%0d err=%0d, required 0 0",
               valid_cnt - v0, err_cnt - e0);
    end
    decode_symbol("rst_after", 1'b1, 32'b01111, 5, 2, 3, 1'b0, 1'b0);
    bif.dc_ready = 1'b0;
    send_bits("rst_hold", 1'b0, 32'b00, 2, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bif.dc_valid !== 1'b0 || bif.bit_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_hold: valid=%0b ready=%0b, required 0 1", bif.dc_valid, bif.bit_ready);
    end
    step();
    rst_n        = 1'b1;
    bif.dc_ready = 1'b1;
    step();
    decode_symbol("rst_hold_next", 1'b0, 32'b010, 3, 1, -1, 1'b0, 1'b0);
  endtask

  initial begin
    bif.bit_in       = 1'b0;
    bif.bit_valid    = 1'b0;
    bif.is_luminance = 1'b1;
    bif.dc_ready     = 1'b1;
    rst_n            = 1'b0;
    step();
    step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_directed(1'b0);
    test_directed(1'b1);
    test_random();
    test_backpressure();
    test_illegal("luma_9_ones", 1'b1, 32'h1FF, 9);
    test_illegal("chroma_11_ones", 1'b0, 32'h7FF, 11);
    test_maxcat();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
